uart_mem: RTL and testbench
===========================

# uart_mem

Memory-mapped 8N1 UART peripheral with a simple enable/ready register bus, programmable 16-bit baud divisor, one-byte TX and RX buffers, and maskable interrupts. It sits on the SoC peripheral bus as a slave. `bus_err` flags misaligned, unsupported-size or unmapped accesses.

## Interface
- `ADDR_WIDTH`, 32: bus address width; only `addr[4:0]` is decoded, and any nonzero higher bit is unmapped.
- `DATA_WIDTH`, 32: bus data width.
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `enable` in 1: transaction request; held until `ready` is seen.
- `wr_en` in 1: 1 = write, 0 = read; sampled with `enable`.
- `addr` in ADDR_WIDTH: byte address.
- `i_data` in DATA_WIDTH: write data, right-justified.
- `be` in 4: access size code. `0001` = byte, `0011` = half, `1111` = word; any other value is a bus error.
- `ready` out 1: transaction complete.
- `o_data` out DATA_WIDTH: read data, right-justified, unused bytes zero.
- `irq` out 1: `|(INT & INT_PENDING)`.
- `bus_err` out 1: error response, valid with `ready`.
- `tx_pin` out 1: serial out, idle high.
- `rx_pin` in 1: serial in, asynchronous.

## Operation
- Register map, one word slot each:
  - BAUD_L 0x00: 16-bit divisor. Byte 0x00 = div[7:0], byte 0x01 = div[15:8].
  - BAUD_H 0x04: div[15:8].
  - STATUS 0x08, read-only: bit0 RX_READY, bit1 TX_BUSY.
  - DATA 0x0C: write starts TX; read returns the RX byte.
  - INT 0x10: enables, bit0 RX_READY, bit1 TX_EMPTY.
  - INT_PENDING 0x14: write-1-to-clear.
- Access validity. An access is valid only when all of the following hold:
  - `be` is a legal size code.
  - `addr` is aligned to the size.
  - The word offset is ≤ 0x14.
  - For byte and half accesses, every addressed byte is implemented: 0x00, 0x01, 0x04, 0x08, 0x0C, 0x10, 0x14.
- Invalid accesses have no side effects, set `bus_err`=1 and `o_data`=0.
- Word accesses to aligned slots are valid. Unimplemented bytes read 0 and writes to them are ignored.
- Data is right-justified. A byte write to 0x01 uses `i_data[7:0]`.
- Writes to STATUS are ignored without error.
- DATA write while TX_BUSY: the byte is dropped, no error.
- DATA read: returns the last received byte, clears RX_READY and INT_PENDING[0].
- TX frame: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts `div` clocks, and a divisor of 0 acts as 1. The divisor is latched at frame start.
- TX frame end sets INT_PENDING[1].
- RX path:
  - `rx_pin` passes through a 2-flop synchronizer.
  - A falling edge starts a frame; the start bit is re-checked at `div/2`. If it is high, the frame is aborted as a glitch.
  - Data bits are sampled at bit centers.
  - Stop bit 1: store the byte, set RX_READY and INT_PENDING[0]. A new byte overwrites an unread one.
  - Stop bit 0: discard the byte.
- INT_PENDING bits set regardless of INT. A set event in the same cycle as a W1C clear wins.

## Timing
- Bus FSM has two states, IDLE and RESP.
  - IDLE + `enable`: perform the access on that edge and go to RESP. `ready`=1 and `bus_err`/`o_data` are registered with it.
  - RESP: hold the outputs while `enable`=1. On `enable`=0, go to IDLE and clear `ready`, `bus_err` and `o_data` on that edge.
  - A new transaction needs at least one cycle with `enable` low. Side effects happen exactly once, on the IDLE→RESP edge.
- Latency: `ready` is high on the first edge after `enable` is sampled.
- Reset values:
  - `ready`=0, `bus_err`=0, `o_data`=0, `irq`=0, `tx_pin`=1.
  - div=434, STATUS=0, INT=0, INT_PENDING=0, RX byte=0.
- Reset mid-frame aborts TX and RX immediately and drives `tx_pin` high.
- TX starts on the edge after the DATA write. A looped-back byte sets RX_READY within 10·div + 4 clocks.

## Configuration
- `UART_MEM_IRQ_EN` defined: INT and INT_PENDING are implemented and `irq` is driven as specified.
- `UART_MEM_IRQ_EN` undefined: `irq` is tied 0. 0x10 and 0x14 remain valid addresses, read 0 and ignore writes.

## Test plan
- Half-word write of 0x01B2 to 0x00, then half read → 0x000001B2. Byte writes 0xB2 to 0x00 and 0x01 to 0x04, then byte reads → 0xB2 and 0x01. `bus_err`=0 throughout.
- Word writes to 0x01, 0x02 and 0x03, half write to 0x01, word write to 0x18, half write to 0x16, byte write to 0x15: each gives `bus_err`=1 and `ready`=1, then `bus_err`=0 on the next idle cycle.
- Loopback `rx_pin`=`tx_pin`, div=434: STATUS byte reads 0. Write 0xAA to DATA and wait 8+15·434 clocks. STATUS reads 0x01, DATA reads 0xAA, STATUS then reads 0x00.
- With IRQ enabled, INT=0x01 and loopback of 0x55: `irq`=1 after reception. INT_PENDING reads 0x03. Writing 0x03 to INT_PENDING drives `irq`=0.
- A second DATA write while TX_BUSY is dropped: only the first byte is received.
- Reset asserted mid-TX: `tx_pin`=1 immediately and all registers return to their reset values.

Source files
------------

// File: rtl/uart_mem.sv
// uart_mem: memory-mapped 8N1 UART with baud divisor, one-byte TX/RX buffers and maskable interrupts.
// Define UART_MEM_IRQ_EN to implement INT/INT_PENDING and drive irq; otherwise irq is tied low.
module uart_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [3:0]            be,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  irq,
    output logic                  bus_err,
    output logic                  tx_pin,
    input  logic                  rx_pin
);
    typedef enum logic {IDLE, RESP} bus_state_t;
    bus_state_t state, state_nxt;

    logic [15:0] div, div_eff;
    logic [4:0]  off;
    logic        size_ok, align_ok, impl_ok, valid, fire, acc_wr, acc_rd;
    logic [31:0] rdata;
    logic [4:0]  lane_a;
    logic [7:0]  lane_d;
    logic        hit_dl, hit_dh, hit_data, hit_int, hit_pend;
    logic [7:0]  wd_dl, wd_dh, wd_data;
    logic [1:0]  wd_int, wd_pend;
    logic [1:0]  int_en, int_pend;
    logic        data_wr, data_rd;

    logic        tx_req, tx_active, tx_busy, tx_set;
    logic [7:0]  tx_buf;
    logic [8:0]  tx_shift;
    logic [15:0] tx_cnt, tx_div;
    logic [3:0]  tx_bit;

    logic        rx_s1, rx_s2, rx_s3, rx_active, rx_set, rx_ready;
    logic [15:0] rx_cnt, rx_div;
    logic [3:0]  rx_bit;
    logic [7:0]  rx_shift, rx_byte;

    function automatic logic impl_byte(input logic [4:0] a);
        return a inside {5'h00, 5'h01, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14};
    endfunction

    assign off     = addr[4:0];
    assign div_eff = (div == 16'd0) ? 16'd1 : div;
    assign tx_busy = tx_req | tx_active;
    assign tx_set  = tx_active && tx_cnt == 16'd0 && tx_bit == 4'd9;
    assign rx_set  = rx_active && rx_cnt == 16'd0 && rx_bit == 4'd9 && rx_s2;

    always_comb begin
        size_ok  = be == 4'b0001 || be == 4'b0011 || be == 4'b1111;
        align_ok = (be == 4'b1111) ? off[1:0] == 2'b00 : (be == 4'b0011) ? !off[0] : 1'b1;
        impl_ok  = be == 4'b1111 || (impl_byte(off) && (be == 4'b0001 || impl_byte(off + 5'd1)));
        valid    = size_ok && align_ok && impl_ok && off[4:2] <= 3'd5 && addr[ADDR_WIDTH-1:5] == '0;
    end

    assign fire    = state == IDLE && enable;
    assign acc_wr  = fire && valid && wr_en;
    assign acc_rd  = fire && valid && !wr_en;
    assign data_wr = acc_wr && hit_data && !tx_busy;
    assign data_rd = acc_rd && hit_data;

    // Each enabled lane k addresses byte off+k and carries i_data[8k+7:8k] (right-justified).
    always_comb begin
        rdata    = '0;
        lane_a   = '0;
        lane_d   = '0;
        hit_dl   = 1'b0;
        hit_dh   = 1'b0;
        hit_data = 1'b0;
        hit_int  = 1'b0;
        hit_pend = 1'b0;
        wd_dl    = '0;
        wd_dh    = '0;
        wd_data  = '0;
        wd_int   = '0;
        wd_pend  = '0;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
                lane_a = off + 5'(k);
                lane_d = i_data[8*k +: 8];
                case (lane_a)
                    5'h00: begin rdata[8*k +: 8] = div[7:0]; hit_dl = 1'b1; wd_dl = lane_d; end
                    5'h01, 5'h04: begin rdata[8*k +: 8] = div[15:8]; hit_dh = 1'b1; wd_dh = lane_d; end
                    5'h08: rdata[8*k +: 8] = {6'd0, tx_busy, rx_ready};
                    5'h0C: begin rdata[8*k +: 8] = rx_byte; hit_data = 1'b1; wd_data = lane_d; end
                    5'h10: begin rdata[8*k +: 8] = {6'd0, int_en}; hit_int = 1'b1; wd_int = lane_d[1:0]; end
                    5'h14: begin rdata[8*k +: 8] = {6'd0, int_pend}; hit_pend = 1'b1; wd_pend = lane_d[1:0]; end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == IDLE && enable)      state_nxt = RESP;
        else if (state == RESP && !enable) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready   <= 1'b0;
            bus_err <= 1'b0;
            o_data  <= '0;
        end else if (fire) begin
            ready   <= 1'b1;
            bus_err <= !valid;
            o_data  <= (valid && !wr_en) ? DATA_WIDTH'(rdata) : '0;
        end else if (state == RESP && !enable) begin
            ready   <= 1'b0;
            bus_err <= 1'b0;
            o_data  <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= 16'd434;
        end else begin
            if (acc_wr && hit_dl) div[7:0]  <= wd_dl;
            if (acc_wr && hit_dh) div[15:8] <= wd_dh;
        end
    end

    // The DATA write only queues the byte; the frame begins on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_req    <= 1'b0;
            tx_buf    <= '0;
            tx_active <= 1'b0;
            tx_shift  <= '1;
            tx_cnt    <= '0;
            tx_div    <= 16'd1;
            tx_bit    <= '0;
            tx_pin    <= 1'b1;
        end else begin
            if (data_wr) begin
                tx_req <= 1'b1;
                tx_buf <= wd_data;
            end
            if (tx_req) begin
                tx_req    <= 1'b0;
                tx_active <= 1'b1;
                tx_pin    <= 1'b0;
                tx_shift  <= {1'b1, tx_buf};
                tx_div    <= div_eff;
                tx_cnt    <= div_eff - 16'd1;
                tx_bit    <= '0;
            end else if (tx_active) begin
                if (tx_cnt != 16'd0) begin
                    tx_cnt <= tx_cnt - 16'd1;
                end else if (tx_bit == 4'd9) begin
                    tx_active <= 1'b0;
                    tx_pin    <= 1'b1;
                end else begin
                    tx_pin   <= tx_shift[0];
                    tx_shift <= {1'b1, tx_shift[8:1]};
                    tx_cnt   <= tx_div - 16'd1;
                    tx_bit   <= tx_bit + 4'd1;
                end
            end
        end
    end

    // rx_s3 is the previous synchronized level, used only for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_s3     <= 1'b1;
            rx_active <= 1'b0;
            rx_cnt    <= '0;
            rx_div    <= 16'd1;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_byte   <= '0;
            rx_ready  <= 1'b0;
        end else begin
            rx_s1 <= rx_pin;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
            if (!rx_active) begin
                if (rx_s3 && !rx_s2) begin
                    rx_active <= 1'b1;
                    rx_div    <= div_eff;
                    rx_cnt    <= div_eff >> 1;
                    rx_bit    <= '0;
                end
            end else if (rx_cnt != 16'd0) begin
                rx_cnt <= rx_cnt - 16'd1;
            end else begin
                rx_cnt <= rx_div - 16'd1;
                rx_bit <= rx_bit + 4'd1;
                if ((rx_bit == 4'd0 && rx_s2) || rx_bit == 4'd9) rx_active <= 1'b0;
                else if (rx_bit != 4'd0)                         rx_shift  <= {rx_s2, rx_shift[7:1]};
            end
            if (rx_set) begin
                rx_byte  <= rx_shift;
                rx_ready <= 1'b1;
            end else if (data_rd) begin
                rx_ready <= 1'b0;
            end
        end
    end

`ifdef UART_MEM_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_en   <= '0;
            int_pend <= '0;
        end else begin
            if (acc_wr && hit_int) int_en <= wd_int;
            int_pend <= (int_pend & ~(({2{acc_wr && hit_pend}} & wd_pend) | {1'b0, data_rd}))
                        | {tx_set, rx_set};
        end
    end
    assign irq = |(int_en & int_pend);
`else
    logic unused_irq;
    assign int_en     = '0;
    assign int_pend   = '0;
    assign irq        = 1'b0;
    assign unused_irq = ^{hit_int, hit_pend, wd_int, wd_pend, tx_set};
`endif
endmodule

// File: tb/tb_uart_mem.sv
// tb_uart_mem: directed self-checking bench for uart_mem (register bus, TX framing, RX, loopback, irq, reset).
module tb_uart_mem;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] i_data = '0;
    logic [3:0]  be = '0;
    logic        ready, irq, bus_err, tx_pin, rx_pin;
    logic [31:0] o_data;
    logic        loop = 1'b0;
    logic        rx_drv = 1'b1;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] r_data;
    logic        r_err;
    int          r_lat;
    logic        p_ready, p_err;
    logic [31:0] p_data;

    assign rx_pin = loop ? tx_pin : rx_drv;

    uart_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .addr(addr),
        .i_data(i_data), .be(be), .ready(ready), .o_data(o_data), .irq(irq),
        .bus_err(bus_err), .tx_pin(tx_pin), .rx_pin(rx_pin)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        enable = 1'b1; wr_en = w; addr = a; i_data = d; be = b; r_lat = 0;
        do begin
            @(posedge clk); #1;
            r_lat++;
        end while (ready !== 1'b1 && r_lat < 8);
        checks++;
        if (ready !== 1'b1) begin failures++; $display("FAIL ready_timeout addr=%h got ready=%b want 1", a, ready); end
        r_data = o_data;
        r_err  = bus_err;
        @(negedge clk);
        enable = 1'b0; wr_en = 1'b0;
        @(posedge clk); #1;
        p_ready = ready; p_err = bus_err; p_data = o_data;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        xfer(1'b1, a, d, b);
    endtask

    task automatic rd(input logic [31:0] a, input logic [3:0] b);
        xfer(1'b0, a, 32'h0, b);
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic sb);
        logic [9:0] f;
        f = {sb, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); rx_drv = f[i];
            repeat (7) @(negedge clk);
        end
        @(negedge clk); rx_drv = 1'b1;
        repeat (20) @(posedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++;
        if ({ready, bus_err, irq, tx_pin} !== 4'b0001) begin failures++; $display("FAIL reset_outs got=%b want=0001", {ready, bus_err, irq, tx_pin}); end
        checks++;
        if (o_data !== 32'h0) begin failures++; $display("FAIL reset_odata got=%h want=0", o_data); end
        @(negedge clk) rst_n = 1'b1;
        rd(32'h00, 4'b0011);
        checks++;
        if (r_data !== 32'h1B2) begin failures++; $display("FAIL reset_div got=%h want=1b2", r_data); end
        checks++;
        if (r_lat !== 1) begin failures++; $display("FAIL read_latency got=%0d want=1", r_lat); end
        rd(32'h08, 4'b0001);
        checks++;
        if (r_data !== 32'h0) begin failures++; $display("FAIL reset_status got=%h want=0", r_data); end
        rd(32'h10, 4'b1111);
        checks++;
        if (r_data !== 32'h0) begin failures++; $display("FAIL reset_int got=%h want=0", r_data); end
        rd(32'h14, 4'b1111);
        checks++;
        if (r_data !== 32'h0) begin failures++; $display("FAIL reset_pend got=%h want=0", r_data); end
        rd(32'h0C, 4'b0001);
        checks++;
        if (r_data !== 32'h0) begin failures++; $display("FAIL reset_rxbyte got=%h want=0", r_data); end
    endtask

    task automatic test_baud;
        wr(32'h00, 32'h0000_1234, 4'b0011);
        checks++;
        if (r_err !== 1'b0) begin failures++; $display("FAIL baud_half_wr_err got=%b want=0", r_err); end
        rd(32'h00, 4'b0011);
        checks++;
        if (r_data !== 32'h1234) begin failures++; $display("FAIL baud_half_rd got=%h want=1234", r_data); end
        rd(32'h04, 4'b1111);
        checks++;
        if (r_data !== 32'h12) begin failures++; $display("FAIL baud_h_word got=%h want=12", r_data); end
        rd(32'h01, 4'b0001);
        checks++;
        if (r_data !== 32'h12) begin failures++; $display("FAIL baud_byte1 got=%h want=12", r_data); end
        wr(32'h00, 32'h0000_01B2, 4'b0011);
        rd(32'h00, 4'b0011);
        checks++;
        if (r_data !== 32'h1B2 || r_err !== 1'b0) begin failures++; $display("FAIL baud_1b2 got=%h err=%b want=1b2 err=0", r_data, r_err); end
        wr(32'h00, 32'h0000_FFFF, 4'b0011);
        wr(32'h00, 32'h0000_00B2, 4'b0001);
        wr(32'h04, 32'h0000_0001, 4'b0001);
        checks++;
        if (r_err !== 1'b0) begin failures++; $display("FAIL baud_byte_wr_err got=%b want=0", r_err); end
        rd(32'h00, 4'b0001);
        checks++;
        if (r_data !== 32'hB2) begin failures++; $display("FAIL baud_byte0 got=%h want=b2", r_data); end
        rd(32'h01, 4'b0001);
        checks++;
        if (r_data !== 32'h01) begin failures++; $display("FAIL baud_byte1b got=%h want=01", r_data); end
        wr(32'h00, 32'hDEAD_0007, 4'b1111);
        rd(32'h00, 4'b1111);
        checks++;
        if (r_data !== 32'h7) begin failures++; $display("FAIL baud_word got=%h want=7", r_data); end
        wr(32'h08, 32'hFFFF_FFFF, 4'b1111);
        checks++;
        if (r_err !== 1'b0) begin failures++; $display("FAIL status_wr_err got=%b want=0", r_err); end
        rd(32'h08, 4'b1111);
        checks++;
        if (r_data !== 32'h0) begin failures++; $display("FAIL status_ro got=%h want=0", r_data); end
        wr(32'h00, 32'h0000_01B2, 4'b0011);
    endtask

    task automatic test_bus_err;
        logic        ws [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] as [12] = '{32'h01, 32'h02, 32'h03, 32'h01, 32'h18, 32'h16, 32'h15, 32'h04, 32'h00, 32'h100, 32'h02, 32'h0D};
        logic [3:0]  bs [12] = '{4'hF, 4'hF, 4'hF, 4'h3, 4'hF, 4'h3, 4'h1, 4'h3, 4'h2, 4'h1, 4'hF, 4'h1};
        for (int i = 0; i < 12; i++) begin
            xfer(ws[i], as[i], 32'hFFFF_FFFF, bs[i]);
            checks++;
            if (r_err !== 1'b1 || r_data !== 32'h0) begin failures++; $display("FAIL bus_err_%0d got err=%b data=%h want err=1 data=0", i, r_err, r_data); end
            checks++;
            if (p_ready !== 1'b0 || p_err !== 1'b0 || p_data !== 32'h0) begin failures++; $display("FAIL bus_err_clear_%0d got rdy=%b err=%b data=%h want 0", i, p_ready, p_err, p_data); end
        end
        rd(32'h00, 4'b0011);
        checks++;
        if (r_data !== 32'h1B2) begin failures++; $display("FAIL bus_err_no_side_effect got=%h want=1b2", r_data); end
        rd(32'h14, 4'b1111);
        checks++;
        if (r_err !== 1'b0) begin failures++; $display("FAIL word_0x14_valid got err=%b want=0", r_err); end
    endtask

    task automatic test_tx_frame;
        logic [9:0] fr;
        int n;
        fr = {1'b1, 8'h4B, 1'b0};
        wr(32'h00, 32'h4, 4'b0011);
        wr(32'h0C, 32'h4B, 4'b0001);
        checks++;
        if (tx_pin !== 1'b0) begin failures++; $display("FAIL tx_start got=%b want=0", tx_pin); end
        repeat (2) @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (tx_pin !== fr[i]) begin failures++; $display("FAIL tx_bit_%0d got=%b want=%b", i, tx_pin, fr[i]); end
            repeat (4) @(posedge clk); #1;
        end
        wr(32'h00, 32'h0, 4'b0011);
        wr(32'h0C, 32'h00, 4'b0001);
        n = 0;
        while (tx_pin === 1'b0 && n < 100) begin n++; @(posedge clk); #1; end
        checks++;
        if (n !== 9) begin failures++; $display("FAIL tx_div0_low got=%0d want=9", n); end
        repeat (5) @(posedge clk);
        wr(32'h00, 32'h2, 4'b0011);
        wr(32'h0C, 32'h00, 4'b0001);
        n = 0;
        while (tx_pin === 1'b0 && n < 100) begin n++; @(posedge clk); #1; end
        checks++;
        if (n !== 18) begin failures++; $display("FAIL tx_div2_low got=%0d want=18", n); end
        repeat (10) @(posedge clk);
    endtask

    task automatic test_rx;
        wr(32'h00, 32'h8, 4'b0011);
        drive_rx(8'h3C, 1'b1);
        rd(32'h08, 4'b0001);
        checks++;
        if (r_data !== 32'h01) begin failures++; $display("FAIL rx_ready got=%h want=01", r_data); end
        rd(32'h0C, 4'b0001);
        checks++;
        if (r_data !== 32'h3C) begin failures++; $display("FAIL rx_byte got=%h want=3c", r_data); end
        @(negedge clk) rx_drv = 1'b0;
        repeat (2) @(negedge clk);
        rx_drv = 1'b1;
        repeat (20) @(posedge clk);
        rd(32'h08, 4'b0001);
        checks++;
        if (r_data !== 32'h00) begin failures++; $display("FAIL rx_glitch got=%h want=00", r_data); end
        drive_rx(8'h77, 1'b0);
        rd(32'h08, 4'b0001);
        checks++;
        if (r_data !== 32'h00) begin failures++; $display("FAIL rx_bad_stop got=%h want=00", r_data); end
        drive_rx(8'h11, 1'b1);
        drive_rx(8'h22, 1'b1);
        rd(32'h0C, 4'b0001);
        checks++;
        if (r_data !== 32'h22) begin failures++; $display("FAIL rx_overwrite got=%h want=22", r_data); end
    endtask

    task automatic test_loopback;
        wr(32'h00, 32'h1B2, 4'b0011);
        loop = 1'b1;
        rd(32'h08, 4'b0001);
        checks++;
        if (r_data !== 32'h00) begin failures++; $display("FAIL lb_status0 got=%h want=00", r_data); end
        wr(32'h0C, 32'hAA, 4'b0001);
        rd(32'h08, 4'b0001);
        checks++;
        if (r_data !== 32'h02) begin failures++; $display("FAIL lb_tx_busy got=%h want=02", r_data); end
        repeat (8 + 15 * 434) @(posedge clk);
        rd(32'h08, 4'b0001);
        checks++;
        if (r_data !== 32'h01) begin failures++; $display("FAIL lb_status1 got=%h want=01", r_data); end
        rd(32'h0C, 4'b0001);
        checks++;
        if (r_data !== 32'hAA) begin failures++; $display("FAIL lb_data got=%h want=aa", r_data); end
        rd(32'h08, 4'b0001);
        checks++;
        if (r_data !== 32'h00) begin failures++; $display("FAIL lb_status_cleared got=%h want=00", r_data); end
        loop = 1'b0;
    endtask

    task automatic test_back_to_back;
        wr(32'h00, 32'h10, 4'b0011);
        loop = 1'b1;
        wr(32'h0C, 32'h5A, 4'b0001);
        wr(32'h0C, 32'hC3, 4'b0001);
        checks++;
        if (r_err !== 1'b0) begin failures++; $display("FAIL b2b_drop_err got=%b want=0", r_err); end
        repeat (360) @(posedge clk);
        rd(32'h08, 4'b0001);
        checks++;
        if (r_data !== 32'h01) begin failures++; $display("FAIL b2b_status got=%h want=01", r_data); end
        rd(32'h0C, 4'b0001);
        checks++;
        if (r_data !== 32'h5A) begin failures++; $display("FAIL b2b_data got=%h want=5a", r_data); end
        repeat (200) @(posedge clk);
        rd(32'h08, 4'b0001);
        checks++;
        if (r_data !== 32'h00) begin failures++; $display("FAIL b2b_no_second got=%h want=00", r_data); end
        loop = 1'b0;
    endtask

    task automatic test_irq;
        wr(32'h00, 32'h10, 4'b0011);
        wr(32'h14, 32'h3, 4'b0001);
`ifdef UART_MEM_IRQ_EN
        wr(32'h10, 32'h1, 4'b0001);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_idle got=%b want=0", irq); end
        loop = 1'b1;
        wr(32'h0C, 32'h55, 4'b0001);
        repeat (200) @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_set got=%b want=1", irq); end
        rd(32'h14, 4'b0001);
        checks++;
        if (r_data !== 32'h03) begin failures++; $display("FAIL irq_pend got=%h want=03", r_data); end
        rd(32'h10, 4'b0001);
        checks++;
        if (r_data !== 32'h01) begin failures++; $display("FAIL irq_int got=%h want=01", r_data); end
        wr(32'h14, 32'h3, 4'b0001);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_w1c got=%b want=0", irq); end
        rd(32'h14, 4'b0001);
        checks++;
        if (r_data !== 32'h00) begin failures++; $display("FAIL irq_pend_clr got=%h want=00", r_data); end
`else
        wr(32'h10, 32'h3, 4'b0001);
        loop = 1'b1;
        wr(32'h0C, 32'h55, 4'b0001);
        repeat (200) @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_tied got=%b want=0", irq); end
        rd(32'h10, 4'b0001);
        checks++;
        if (r_data !== 32'h00 || r_err !== 1'b0) begin failures++; $display("FAIL int_absent got=%h err=%b want=00 err=0", r_data, r_err); end
        rd(32'h14, 4'b0001);
        checks++;
        if (r_data !== 32'h00 || r_err !== 1'b0) begin failures++; $display("FAIL pend_absent got=%h err=%b want=00 err=0", r_data, r_err); end
`endif
        rd(32'h0C, 4'b0001);
        checks++;
        if (r_data !== 32'h55) begin failures++; $display("FAIL irq_data got=%h want=55", r_data); end
        loop = 1'b0;
    endtask

    task automatic test_reset_mid_tx;
        wr(32'h00, 32'h100, 4'b0011);
        wr(32'h0C, 32'h00, 4'b0001);
        repeat (50) @(posedge clk); #1;
        checks++;
        if (tx_pin !== 1'b0) begin failures++; $display("FAIL mid_tx_low got=%b want=0", tx_pin); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tx_pin !== 1'b1 || ready !== 1'b0) begin failures++; $display("FAIL async_reset got tx=%b rdy=%b want tx=1 rdy=0", tx_pin, ready); end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        rd(32'h00, 4'b0011);
        checks++;
        if (r_data !== 32'h1B2) begin failures++; $display("FAIL rst_div got=%h want=1b2", r_data); end
        rd(32'h08, 4'b0001);
        checks++;
        if (r_data !== 32'h00) begin failures++; $display("FAIL rst_status got=%h want=00", r_data); end
        rd(32'h0C, 4'b0001);
        checks++;
        if (r_data !== 32'h00) begin failures++; $display("FAIL rst_rxbyte got=%h want=00", r_data); end
        rd(32'h10, 4'b0001);
        checks++;
        if (r_data !== 32'h00) begin failures++; $display("FAIL rst_int got=%h want=00", r_data); end
        rd(32'h14, 4'b0001);
        checks++;
        if (r_data !== 32'h00) begin failures++; $display("FAIL rst_pend got=%h want=00", r_data); end
        repeat (20) @(posedge clk); #1;
        checks++;
        if (tx_pin !== 1'b1 || irq !== 1'b0) begin failures++; $display("FAIL rst_tx_idle got tx=%b irq=%b want tx=1 irq=0", tx_pin, irq); end
    endtask

    initial begin
        test_reset();
        test_baud();
        test_bus_err();
        test_tx_frame();
        test_rx();
        test_loopback();
        test_back_to_back();
        test_irq();
        test_reset_mid_tx();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
